hdlc_rx_frame_ctrl: RTL and testbench
=====================================

// Module: hdlc_rx_frame_ctrl
// PURPOSE
//  Sequences the HDLC receive datapath between bit-level detectors and the Rx frame buffer.
//  - Inputs: flag/abort/byte pulses from the destuffer/shift logic.
//  - Tracks frame state; generates buffer write strobes and addresses.
//  - Produces Rx_ValidFrame, Rx_EoF, Rx_AbortSignal, Rx_Overflow and the frame size/ready
//    status read by the register interface.
// PARAMETERS
//  MAX_BYTES  128  buffer depth in bytes; write addresses wrap never, excess bytes flag overflow
//  MIN_BYTES  4    minimum bytes between flags (incl. FCS) for a frame to be accepted
//  FCS_BYTES  2    trailing FCS bytes excluded from Rx_FrameSize
// PORTS
//  Clk             in   1   clock, all logic on posedge
//  Rst             in   1   asynchronous reset, active-high
//  Rx_Enable       in   1   receiver enable; low forces IDLE
//  Rx_FlagDetect   in   1   1-cycle pulse: 01111110 seen
//  Rx_AbortDetect  in   1   1-cycle pulse: 7 consecutive ones seen
//  Rx_NewByte      in   1   1-cycle pulse: destuffed byte assembled
//  Rx_ReadDone     in   1   pulse: reader has consumed the ready frame
//  Rx_Drop         in   1   pulse: software discards current/ready frame
//  Rx_FCSerr       in   1   FCS mismatch, valid with Rx_FlagDetect (only with macro)
//  Rx_ValidFrame   out  1   high while inside an accepted-so-far frame
//  Rx_WrBuff       out  1   buffer write strobe, 1 cycle
//  Rx_WrAddr       out  AW  buffer write address, AW=$clog2(MAX_BYTES)
//  Rx_EoF          out  1   1-cycle pulse: frame ended (any cause)
//  Rx_AbortSignal  out  1   1-cycle pulse: frame aborted
//  Rx_Overflow     out  1   sticky: byte received with buffer full
//  Rx_Ready        out  1   good frame held in buffer
//  Rx_FrameSize    out  CW  payload bytes of ready frame, CW=$clog2(MAX_BYTES+1)
//  Rx_FrameError   out  1   1-cycle pulse with Rx_EoF on FCS rejection
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte count 0.
//  All outputs registered.
//  States:
//   - IDLE: FlagDetect -> FLAG.
//   - FLAG: FlagDetect -> stay (shared/back-to-back flags); NewByte -> FRAME.
//     FLAG->FRAME sets ValidFrame, clears Overflow, writes byte 0.
//   - FRAME:
//     - NewByte with count<MAX_BYTES -> WrBuff=1, WrAddr=count at next cycle, count++.
//     - NewByte with count==MAX_BYTES -> no write, Overflow=1.
//     - FlagDetect -> close (below). AbortDetect -> IDLE.
//   - WAIT: frame owned by reader; all detector pulses ignored; ReadDone or Drop -> IDLE,
//     Ready=0 next cycle.
//  Close on FlagDetect in FRAME at cycle n:
//   - count>=MIN_BYTES: WAIT; Ready=1, FrameSize=count-FCS_BYTES at n+1.
//   - count<MIN_BYTES: discard, -> FLAG (closing flag reopens).
//  Timing:
//   - ValidFrame falls at n+1 on every exit from FRAME (close, abort, Drop, Enable low).
//   - Rx_EoF pulses at n+2, i.e. exactly one cycle after ValidFrame falls.
//   - Abort at cycle n in FRAME: AbortSignal=1 at n+1, no Ready.
//   - AbortDetect outside FRAME: no AbortSignal.
//  Priority (same cycle):
//   - Rst > Enable low > AbortDetect > Drop > FlagDetect > NewByte.
//   - A NewByte coincident with FlagDetect is ignored.
//  Rx_Enable low: next cycle IDLE, Ready=0, count=0; Overflow kept until next frame start.
//  Rx_Drop in FRAME: -> IDLE (hunt new flag), EoF rule applies, no Ready.
//  Overflowed frame closes normally: Ready=1, FrameSize=MAX_BYTES-FCS_BYTES, Overflow stays 1.
//  Reset mid-frame: outputs drop to 0 asynchronously; no EoF generated.
// CONFIGURATION
//  HDLC_RX_FCS_CHECK_EN defined:
//   - Rx_FCSerr port present, sampled on closing FlagDetect.
//   - If 1 and count>=MIN_BYTES: frame discarded, -> IDLE, Ready stays 0,
//     Rx_FrameError pulses with Rx_EoF.
//  Not defined:
//   - Rx_FCSerr port absent; FCS never rejects; Rx_FrameError tied 0.
// TESTING
//  1. Flag, 10 NewByte, flag -> 10 WrBuff at addr 0..9; ValidFrame falls n+1, EoF n+2;
//     Ready=1, FrameSize=8.
//  2. Flag, 5 bytes, AbortDetect -> AbortSignal=1 one cycle after abort, EoF next;
//     Ready=0; back to IDLE.
//  3. Flag, 130 bytes, flag -> 128 writes, Overflow=1 at byte 129;
//     FrameSize=126, Ready=1; Overflow cleared on next frame's first byte.
//  4. Flag, 3 bytes, flag, 6 bytes, flag -> first frame discarded (no Ready);
//     second Ready with FrameSize=4.
//  5. Ready frame, further flags/bytes -> no WrBuff; ReadDone -> Ready=0, new frame accepted.
//  6. Macro on: good frame with Rx_FCSerr=1 at closing flag -> FrameError+EoF, Ready=0;
//     Rst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/hdlc_rx_frame_ctrl.sv
// rtl/hdlc_rx_frame_ctrl.sv - HDLC receive frame sequencer between bit detectors and Rx buffer
// Optional FCS rejection enabled by defining HDLC_RX_FCS_CHECK_EN.
module hdlc_rx_frame_ctrl #(
  parameter int MAX_BYTES = 128,
  parameter int MIN_BYTES = 4,
  parameter int FCS_BYTES = 2,
  localparam int AW = $clog2(MAX_BYTES),
  localparam int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Rx_Enable,
  input  logic          Rx_FlagDetect,
  input  logic          Rx_AbortDetect,
  input  logic          Rx_NewByte,
  input  logic          Rx_ReadDone,
  input  logic          Rx_Drop,
`ifdef HDLC_RX_FCS_CHECK_EN
  input  logic          Rx_FCSerr,
`endif
  output logic          Rx_ValidFrame,
  output logic          Rx_WrBuff,
  output logic [AW-1:0] Rx_WrAddr,
  output logic          Rx_EoF,
  output logic          Rx_AbortSignal,
  output logic          Rx_Overflow,
  output logic          Rx_Ready,
  output logic [CW-1:0] Rx_FrameSize,
  output logic          Rx_FrameError
);

  typedef enum logic [1:0] {IDLE, FLAG, FRAME, WAIT} state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_BYTES);
  localparam logic [CW-1:0] FCS_CNT = CW'(FCS_BYTES);

  state_t        state;
  logic [CW-1:0] count;
  logic          eof_pending;
  logic          err_pending;
  logic          fcs_err;

`ifdef HDLC_RX_FCS_CHECK_EN
  assign fcs_err = Rx_FCSerr;
`else
  assign fcs_err = 1'b0;
`endif

  // EoF and FrameError trail the frame exit by one cycle via the pending flags.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state          <= IDLE;
      count          <= '0;
      eof_pending    <= 1'b0;
      err_pending    <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_WrBuff      <= 1'b0;
      Rx_WrAddr      <= '0;
      Rx_EoF         <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_Ready       <= 1'b0;
      Rx_FrameSize   <= '0;
      Rx_FrameError  <= 1'b0;
    end else begin
      Rx_WrBuff      <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_EoF         <= eof_pending;
      Rx_FrameError  <= err_pending;
      eof_pending    <= 1'b0;
      err_pending    <= 1'b0;
      if (!Rx_Enable) begin
        if (state == FRAME) eof_pending <= 1'b1;
        state         <= IDLE;
        count         <= '0;
        Rx_ValidFrame <= 1'b0;
        Rx_Ready      <= 1'b0;
        Rx_FrameSize  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (Rx_FlagDetect) state <= FLAG;
          end
          FLAG: begin
            if (Rx_NewByte && !Rx_FlagDetect) begin
              state         <= FRAME;
              count         <= CW'(1);
              Rx_ValidFrame <= 1'b1;
              Rx_Overflow   <= 1'b0;
              Rx_WrBuff     <= 1'b1;
              Rx_WrAddr     <= '0;
            end
          end
          FRAME: begin
            if (Rx_AbortDetect) begin
              state          <= IDLE;
              count          <= '0;
              Rx_ValidFrame  <= 1'b0;
              Rx_AbortSignal <= 1'b1;
              eof_pending    <= 1'b1;
            end else if (Rx_Drop) begin
              state         <= IDLE;
              count         <= '0;
              Rx_ValidFrame <= 1'b0;
              eof_pending   <= 1'b1;
            end else if (Rx_FlagDetect) begin
              Rx_ValidFrame <= 1'b0;
              eof_pending   <= 1'b1;
              if (count < MIN_CNT) begin
                // Too short: the closing flag doubles as the next opening flag.
                state <= FLAG;
                count <= '0;
              end else if (fcs_err) begin
                state       <= IDLE;
                count       <= '0;
                err_pending <= 1'b1;
              end else begin
                state        <= WAIT;
                Rx_Ready     <= 1'b1;
                Rx_FrameSize <= count - FCS_CNT;
              end
            end else if (Rx_NewByte) begin
              if (count < MAX_CNT) begin
                Rx_WrBuff <= 1'b1;
                Rx_WrAddr <= count[AW-1:0];
                count     <= count + CW'(1);
              end else begin
                Rx_Overflow <= 1'b1;
              end
            end
          end
          WAIT: begin
            if (Rx_ReadDone || Rx_Drop) begin
              state        <= IDLE;
              count        <= '0;
              Rx_Ready     <= 1'b0;
              Rx_FrameSize <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// tb/tb_hdlc_rx_frame_ctrl.sv - directed vector bench for hdlc_rx_frame_ctrl
// FCS rejection sequence runs only when HDLC_RX_FCS_CHECK_EN is defined.
module tb_hdlc_rx_frame_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx_Enable = 1'b0;
  logic       Rx_FlagDetect = 1'b0;
  logic       Rx_AbortDetect = 1'b0;
  logic       Rx_NewByte = 1'b0;
  logic       Rx_ReadDone = 1'b0;
  logic       Rx_Drop = 1'b0;
`ifdef HDLC_RX_FCS_CHECK_EN
  logic       Rx_FCSerr = 1'b0;
`endif
  logic       Rx_ValidFrame;
  logic       Rx_WrBuff;
  logic [6:0] Rx_WrAddr;
  logic       Rx_EoF;
  logic       Rx_AbortSignal;
  logic       Rx_Overflow;
  logic       Rx_Ready;
  logic [7:0] Rx_FrameSize;
  logic       Rx_FrameError;

  always #5 Clk = ~Clk;

  hdlc_rx_frame_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Rx_Enable(Rx_Enable), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_NewByte(Rx_NewByte), .Rx_ReadDone(Rx_ReadDone),
    .Rx_Drop(Rx_Drop),
`ifdef HDLC_RX_FCS_CHECK_EN
    .Rx_FCSerr(Rx_FCSerr),
`endif
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_WrBuff(Rx_WrBuff), .Rx_WrAddr(Rx_WrAddr),
    .Rx_EoF(Rx_EoF), .Rx_AbortSignal(Rx_AbortSignal), .Rx_Overflow(Rx_Overflow),
    .Rx_Ready(Rx_Ready), .Rx_FrameSize(Rx_FrameSize), .Rx_FrameError(Rx_FrameError)
  );

  typedef struct {
    logic       en, flag, abort, nb, rd, drop;
    logic       valid, wr;
    logic [6:0] addr;
    logic       eof, abt, ovf, rdy;
    logic [7:0] size;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic en, flag, abort, nb, rd, drop,
                              input logic valid, wr, input logic [6:0] addr,
                              input logic eof, abt, ovf, rdy, input logic [7:0] size);
    vec_t v;
    v.en = en; v.flag = flag; v.abort = abort; v.nb = nb; v.rd = rd; v.drop = drop;
    v.valid = valid; v.wr = wr; v.addr = addr; v.eof = eof; v.abt = abt;
    v.ovf = ovf; v.rdy = rdy; v.size = size;
    vecs.push_back(v);
  endfunction

  task automatic cyc(input logic en, flag, abort, nb, rd, drop);
    @(negedge Clk);
    Rx_Enable = en; Rx_FlagDetect = flag; Rx_AbortDetect = abort;
    Rx_NewByte = nb; Rx_ReadDone = rd; Rx_Drop = drop;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // en flag abort nb rd drop | valid wr addr eof abt ovf rdy size
    add(1,0,0,0,0,0, 0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 10; i++) add(1,0,0,1,0,0, 1,1,7'(i), 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,1,8);
    add(1,0,0,0,0,0, 0,0,0, 1,0,0,1,8);
    add(1,0,0,0,0,0, 0,0,0, 0,0,0,1,8);
    add(1,0,0,0,1,0, 0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 5; i++) add(1,0,0,1,0,0, 1,1,7'(i), 0,0,0,0,0);
    add(1,0,1,0,0,0, 0,0,0, 0,1,0,0,0);
    add(1,0,0,0,0,0, 0,0,0, 1,0,0,0,0);
    add(1,0,0,1,0,0, 0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,1,0,0, 1,1,7'(i), 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0,0, 1,1,0, 1,0,0,0,0);
    for (int i = 1; i < 6; i++) add(1,0,0,1,0,0, 1,1,7'(i), 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,1,4);
    add(1,0,0,0,0,0, 0,0,0, 1,0,0,1,4);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,1,4);
    add(1,0,0,1,0,0, 0,0,0, 0,0,0,1,4);
    add(1,0,1,0,0,0, 0,0,0, 0,0,0,1,4);
    add(1,0,0,0,1,0, 0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0,0, 1,1,0, 0,0,0,0,0);
    add(1,0,0,0,0,1, 0,0,0, 0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0, 1,0,0,0,0);
    add(1,0,0,1,0,0, 0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0,0, 1,1,0, 0,0,0,0,0);
    add(1,1,0,1,0,0, 0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0,0, 1,1,0, 1,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0, 1,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0,0, 1,1,0, 0,0,0,0,0);
    add(1,1,1,0,0,0, 0,0,0, 0,1,0,0,0);
    add(1,0,0,0,0,0, 0,0,0, 1,0,0,0,0);

    repeat (2) @(posedge Clk);
    #1;
    chk("reset.valid", 32'(Rx_ValidFrame), 0);
    chk("reset.wr", 32'(Rx_WrBuff), 0);
    chk("reset.addr", 32'(Rx_WrAddr), 0);
    chk("reset.eof", 32'(Rx_EoF), 0);
    chk("reset.ovf", 32'(Rx_Overflow), 0);
    chk("reset.rdy", 32'(Rx_Ready), 0);
    chk("reset.size", 32'(Rx_FrameSize), 0);
    @(negedge Clk);
    Rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].flag, vecs[i].abort, vecs[i].nb, vecs[i].rd, vecs[i].drop);
      chk($sformatf("v%0d.valid", i), 32'(Rx_ValidFrame), 32'(vecs[i].valid));
      chk($sformatf("v%0d.wr", i), 32'(Rx_WrBuff), 32'(vecs[i].wr));
      if (vecs[i].wr) chk($sformatf("v%0d.addr", i), 32'(Rx_WrAddr), 32'(vecs[i].addr));
      chk($sformatf("v%0d.eof", i), 32'(Rx_EoF), 32'(vecs[i].eof));
      chk($sformatf("v%0d.abort", i), 32'(Rx_AbortSignal), 32'(vecs[i].abt));
      chk($sformatf("v%0d.ovf", i), 32'(Rx_Overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d.ready", i), 32'(Rx_Ready), 32'(vecs[i].rdy));
      if (vecs[i].rdy) chk($sformatf("v%0d.size", i), 32'(Rx_FrameSize), 32'(vecs[i].size));
      chk($sformatf("v%0d.ferr", i), 32'(Rx_FrameError), 0);
    end

    // Overflow: 130 bytes into a 128-byte buffer
    cyc(1,1,0,0,0,0);
    for (int i = 0; i < 130; i++) begin
      cyc(1,0,0,1,0,0);
      if (i < 128) begin
        chk($sformatf("ovf.wr%0d", i), 32'(Rx_WrBuff), 1);
        chk($sformatf("ovf.addr%0d", i), 32'(Rx_WrAddr), 32'(i));
        chk($sformatf("ovf.flag%0d", i), 32'(Rx_Overflow), 0);
      end else begin
        chk($sformatf("ovf.wr%0d", i), 32'(Rx_WrBuff), 0);
        chk($sformatf("ovf.flag%0d", i), 32'(Rx_Overflow), 1);
      end
    end
    cyc(1,1,0,0,0,0);
    chk("ovf.close.ready", 32'(Rx_Ready), 1);
    chk("ovf.close.size", 32'(Rx_FrameSize), 126);
    chk("ovf.close.sticky", 32'(Rx_Overflow), 1);
    chk("ovf.close.valid", 32'(Rx_ValidFrame), 0);
    cyc(1,0,0,0,0,0);
    chk("ovf.eof", 32'(Rx_EoF), 1);
    cyc(1,0,0,0,1,0);
    chk("ovf.read.ready", 32'(Rx_Ready), 0);
    chk("ovf.read.sticky", 32'(Rx_Overflow), 1);
    cyc(1,1,0,0,0,0);
    cyc(1,0,0,1,0,0);
    chk("ovf.newframe.clear", 32'(Rx_Overflow), 0);
    chk("ovf.newframe.addr", 32'(Rx_WrAddr), 0);
    cyc(1,0,0,0,0,1);
    cyc(1,0,0,0,0,0);

`ifdef HDLC_RX_FCS_CHECK_EN
    cyc(1,1,0,0,0,0);
    for (int i = 0; i < 4; i++) cyc(1,0,0,1,0,0);
    @(negedge Clk);
    Rx_FCSerr = 1'b1;
    cyc(1,1,0,0,0,0);
    Rx_FCSerr = 1'b0;
    chk("fcs.valid", 32'(Rx_ValidFrame), 0);
    chk("fcs.ready", 32'(Rx_Ready), 0);
    chk("fcs.ferr_early", 32'(Rx_FrameError), 0);
    cyc(1,0,0,0,0,0);
    chk("fcs.eof", 32'(Rx_EoF), 1);
    chk("fcs.ferr", 32'(Rx_FrameError), 1);
    chk("fcs.ready2", 32'(Rx_Ready), 0);
    cyc(1,0,0,1,0,0);
    chk("fcs.idle_wr", 32'(Rx_WrBuff), 0);
    chk("fcs.ferr_gone", 32'(Rx_FrameError), 0);
`endif

    // Asynchronous reset mid-frame
    cyc(1,1,0,0,0,0);
    cyc(1,0,0,1,0,0);
    cyc(1,0,0,1,0,0);
    chk("rst.pre_valid", 32'(Rx_ValidFrame), 1);
    chk("rst.pre_wr", 32'(Rx_WrBuff), 1);
    #2;
    Rst = 1'b1;
    #1;
    chk("rst.valid", 32'(Rx_ValidFrame), 0);
    chk("rst.wr", 32'(Rx_WrBuff), 0);
    chk("rst.addr", 32'(Rx_WrAddr), 0);
    chk("rst.ready", 32'(Rx_Ready), 0);
    @(negedge Clk);
    Rst = 1'b0;
    cyc(1,0,0,0,0,0);
    chk("rst.no_eof1", 32'(Rx_EoF), 0);
    cyc(1,0,0,1,0,0);
    chk("rst.no_eof2", 32'(Rx_EoF), 0);
    chk("rst.idle_wr", 32'(Rx_WrBuff), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
